// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with hold/bubble control and
// storage for the two-cycle multiply-accumulate intermediate product.
module ex_mem_reg #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int STALL_W = 6,
    parameter int EX_IDX  = 3,
    parameter int MEM_IDX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic                ex_whilo,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic                mem_whilo,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);
    logic                w_s_ex, w_s_mem, w_advance, w_bubble, w_unused;
    logic [ADDR_W-1:0]   r_wd;
    logic                r_wreg, r_whilo;
    logic [DATA_W-1:0]   r_wdata, r_hi, r_lo;
    logic [2*DATA_W-1:0] r_hilo;
    logic [1:0]          r_cnt;
    assign w_s_ex    = stall[EX_IDX];
    assign w_s_mem   = stall[MEM_IDX];
    // Advance needs MEM free too, so the illegal EX-free/MEM-stalled case holds.
    assign w_advance = !w_s_ex && !w_s_mem;
    assign w_bubble  = w_s_ex && !w_s_mem;
    assign w_unused  = ^stall;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd    <= '0;
            r_wreg  <= 1'b0;
            r_wdata <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= 1'b0;
            r_hilo  <= '0;
            r_cnt   <= '0;
        end else if (w_advance) begin
            r_wd    <= ex_wd;
            r_wreg  <= ex_wreg;
            r_wdata <= ex_wdata;
            r_hi    <= ex_hi;
            r_lo    <= ex_lo;
            r_whilo <= ex_whilo;
            r_hilo  <= '0;
            r_cnt   <= '0;
        end else if (w_bubble) begin
            r_wd    <= '0;
            r_wreg  <= 1'b0;
            r_wdata <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_whilo <= 1'b0;
            r_hilo  <= hilo_i;
            r_cnt   <= cnt_i;
        end
    end
    always_ff @(posedge clk)
        a_stall_monotone: assert (rst || w_s_ex || !w_s_mem)
            else $warning("ex_mem_reg: illegal stall, MEM stalled while EX advances (stall=%b)", stall);
    assign mem_wd    = r_wd;
    assign mem_wreg  = r_wreg;
    assign mem_wdata = r_wdata;
    assign mem_hi    = r_hi;
    assign mem_lo    = r_lo;
    assign mem_whilo = r_whilo;
    assign hilo_o    = r_hilo;
    assign cnt_o     = r_cnt;
endmodule
